// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 keystream controller: FSM states, S-box sizing
// and the key-length clamp.
package rc4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA_A,
        ST_KSA_B,
        ST_PRGA_A,
        ST_PRGA_B,
        ST_PRGA_C,
        ST_OUT
    } rc4_state_e;

    localparam int INIT_CYCLES = 128;
    localparam int SBOX_SIZE   = 256;
    localparam int KEY_LEN_W   = 5;

    // A zero or oversize length means "use the full key".
    function automatic logic [KEY_LEN_W-1:0] clamp_key_len(input logic [KEY_LEN_W-1:0] len,
                                                           input int max_len);
        if (len == '0 || int'(len) > max_len) return KEY_LEN_W'(max_len);
        return len;
    endfunction

endpackage

// File: rtl/rc4_ks_packer.sv
// Packs keystream bytes into an output word, lane by lane, and holds the word
// under a valid/ready handshake.
module rc4_ks_packer
    import rc4_pkg::*;
#(
    parameter int NUMS_OF_BYTES = 4,
    localparam int BW = (NUMS_OF_BYTES > 1) ? $clog2(NUMS_OF_BYTES) : 1
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       capture,
    input  logic                       ks_ready,
    input  logic [NUMS_OF_BYTES*8-1:0] k_data,
    output logic [BW-1:0]              bidx,
    output logic                       last,
    output logic                       ks_valid,
    output logic [NUMS_OF_BYTES*8-1:0] ks_data
);

    assign last = (bidx == BW'(NUMS_OF_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bidx     <= '0;
            ks_valid <= 1'b0;
            ks_data  <= '0;
        end else if (clr) begin
            bidx     <= '0;
            ks_valid <= 1'b0;
        end else if (ks_valid && ks_ready) begin
            bidx     <= '0;
            ks_valid <= 1'b0;
        end else if (capture) begin
            ks_data[bidx*8 +: 8] <= k_data[bidx*8 +: 8];
            if (last) ks_valid <= 1'b1;
            else      bidx     <= bidx + 1'b1;
        end
    end

endmodule

// File: rtl/rc4_ctrl.sv
// RC4 key schedule and keystream generator driving an external 256-byte state RAM.
// State | meaning: IDLE wait start | INIT S[n]=n | KSA_A/B key mix | PRGA_A/B/C byte gen | OUT word held.
module rc4_ctrl
    import rc4_pkg::*;
#(
    parameter int NUMS_OF_BYTES = 4,
    parameter int KEY_BYTES     = 16
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stop,
    input  logic [KEY_BYTES*8-1:0]     key,
    input  logic [4:0]                 key_len,
    output logic                       busy,
    output logic [NUMS_OF_BYTES*8-1:0] ks_data,
    output logic                       ks_valid,
    input  logic                       ks_ready,
    output logic                       wen,
    output logic [7:0]                 raddr_1,
    output logic [7:0]                 waddr_2,
    output logic [7:0]                 addr_3,
    output logic [7:0]                 wdata_2,
    output logic [7:0]                 wdata_3,
    output logic [NUMS_OF_BYTES*8-1:0] k_addr,
    input  logic [7:0]                 rdata_1,
    input  logic [7:0]                 rdata_3,
    input  logic [NUMS_OF_BYTES*8-1:0] k_data
);

    localparam int BW = (NUMS_OF_BYTES > 1) ? $clog2(NUMS_OF_BYTES) : 1;

    rc4_state_e           state, state_nxt;
    logic [7:0]           i, j, si, t;
    logic [4:0]           kidx, klen;
    logic [KEY_BYTES*8-1:0] key_q;
    logic [BW-1:0]        bidx;
    logic                 last;
    logic                 accept;

    assign accept = (state == ST_IDLE) && start && !stop;
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (start) state_nxt = ST_INIT;
                ST_INIT:   if (i == 8'(INIT_CYCLES - 1)) state_nxt = ST_KSA_A;
                ST_KSA_A:  state_nxt = ST_KSA_B;
                ST_KSA_B:  state_nxt = (i == 8'(SBOX_SIZE - 1)) ? ST_PRGA_A : ST_KSA_A;
                ST_PRGA_A: state_nxt = ST_PRGA_B;
                ST_PRGA_B: state_nxt = ST_PRGA_C;
                ST_PRGA_C: state_nxt = last ? ST_OUT : ST_PRGA_A;
                ST_OUT:    if (ks_ready) state_nxt = ST_PRGA_A;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i     <= '0;
            j     <= '0;
            si    <= '0;
            t     <= '0;
            kidx  <= '0;
            klen  <= '0;
            key_q <= '0;
        end else if (stop) begin
            i    <= '0;
            j    <= '0;
            kidx <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    key_q <= key;
                    klen  <= clamp_key_len(key_len, KEY_BYTES);
                    i     <= '0;
                    j     <= '0;
                    kidx  <= '0;
                end
                // i doubles as the INIT pair counter and ends back at 0.
                ST_INIT: i <= (i == 8'(INIT_CYCLES - 1)) ? 8'd0 : i + 8'd1;
                ST_KSA_A: begin
                    si <= rdata_1;
                    j  <= j + rdata_1 + key_q[kidx*8 +: 8];
                end
                ST_KSA_B: begin
                    kidx <= (kidx + 5'd1 >= klen) ? 5'd0 : kidx + 5'd1;
                    i    <= i + 8'd1;
                    if (i == 8'(SBOX_SIZE - 1)) j <= '0;
                end
                ST_PRGA_A: begin
                    i  <= i + 8'd1;
                    si <= rdata_1;
                    j  <= j + rdata_1;
                end
                ST_PRGA_B: t <= si + rdata_3;
                default: ;
            endcase
        end
    end

    always_comb begin
        wen     = 1'b0;
        raddr_1 = '0;
        waddr_2 = '0;
        addr_3  = '0;
        wdata_2 = '0;
        wdata_3 = '0;
        k_addr  = '0;
        case (state)
            ST_INIT: begin
                wen     = 1'b1;
                waddr_2 = {i[6:0], 1'b0};
                wdata_2 = {i[6:0], 1'b0};
                addr_3  = {i[6:0], 1'b1};
                wdata_3 = {i[6:0], 1'b1};
            end
            ST_KSA_A:  raddr_1 = i;
            ST_PRGA_A: raddr_1 = i + 8'd1;
            // S[j] is read through port 3 while it is overwritten with S[i].
            ST_KSA_B, ST_PRGA_B: begin
                wen     = 1'b1;
                addr_3  = j;
                wdata_3 = si;
                waddr_2 = i;
                wdata_2 = rdata_3;
            end
            ST_PRGA_C: k_addr[bidx*8 +: 8] = t;
            default: ;
        endcase
    end

    rc4_ks_packer #(.NUMS_OF_BYTES(NUMS_OF_BYTES)) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (stop || accept),
        .capture  (state == ST_PRGA_C),
        .ks_ready (ks_ready),
        .k_data   (k_data),
        .bidx     (bidx),
        .last     (last),
        .ks_valid (ks_valid),
        .ks_data  (ks_data)
    );

endmodule

// File: tb/tb_rc4_ctrl.sv
// Bench for rc4_ctrl: behavioural state RAM beside the DUT and an
// array-based RC4 reference model for expected keystream words.
module tb_rc4_ctrl;

    localparam int NB = 4;
    localparam int KB = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [KB*8-1:0]   key = '0;
    logic [4:0]        key_len = '0;
    logic              busy;
    logic [NB*8-1:0]   ks_data;
    logic              ks_valid;
    logic              ks_ready = 1'b0;
    logic              wen;
    logic [7:0]        raddr_1, waddr_2, addr_3, wdata_2, wdata_3;
    logic [NB*8-1:0]   k_addr;
    logic [7:0]        rdata_1, rdata_3;
    logic [NB*8-1:0]   k_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rc4_ctrl #(.NUMS_OF_BYTES(NB), .KEY_BYTES(KB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .key(key), .key_len(key_len),
        .busy(busy), .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready),
        .wen(wen), .raddr_1(raddr_1), .waddr_2(waddr_2), .addr_3(addr_3),
        .wdata_2(wdata_2), .wdata_3(wdata_3), .k_addr(k_addr),
        .rdata_1(rdata_1), .rdata_3(rdata_3), .k_data(k_data)
    );

    logic [7:0] sram [0:255];
    assign rdata_1 = sram[raddr_1];
    assign rdata_3 = sram[addr_3];
    for (genvar b = 0; b < NB; b++) begin : g_klane
        assign k_data[b*8 +: 8] = sram[k_addr[b*8 +: 8]];
    end
    always @(posedge clk) begin
        if (wen) begin
            sram[waddr_2] <= wdata_2;
            sram[addr_3]  <= wdata_3;
        end
    end

    byte unsigned ref_q[$];

    task automatic ref_gen(input logic [KB*8-1:0] k, input int len, input int nbytes);
        int s[256];
        int ii, jj, eff, tmp;
        eff = (len == 0 || len > KB) ? KB : len;
        for (int x = 0; x < 256; x++) s[x] = x;
        jj = 0;
        for (int x = 0; x < 256; x++) begin
            jj = (jj + s[x] + int'(k[(x % eff)*8 +: 8])) % 256;
            tmp = s[x]; s[x] = s[jj]; s[jj] = tmp;
        end
        ii = 0; jj = 0;
        ref_q.delete();
        repeat (nbytes) begin
            ii = (ii + 1) % 256;
            jj = (jj + s[ii]) % 256;
            tmp = s[ii]; s[ii] = s[jj]; s[jj] = tmp;
            ref_q.push_back(byte'(s[(s[ii] + s[jj]) % 256]));
        end
    endtask

    function automatic logic [NB*8-1:0] ref_word(input int w);
        logic [NB*8-1:0] r;
        for (int b = 0; b < NB; b++) r[b*8 +: 8] = ref_q[w*NB + b];
        return r;
    endfunction

    task automatic start_run(input logic [KB*8-1:0] k, input logic [4:0] len);
        @(negedge clk);
        key = k; key_len = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic stop_pulse();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // n counts negedges until ks_valid is seen; after start_run it equals the edge index.
    task automatic get_word(output logic [NB*8-1:0] w, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ks_valid && n < 3000);
        if (!ks_valid) begin
            checks++; errors++;
            $display("FAIL word_timeout: ks_valid=%0b after %0d cycles, required 1", ks_valid, n);
        end
        w = ks_data;
    endtask

    function automatic logic [KB*8-1:0] key_key();
        return {104'h0, 8'h79, 8'h65, 8'h4B};
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, ks_valid, wen} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: busy/valid/wen=%b required 000", {busy, ks_valid, wen});
        end
        checks++;
        if (ks_data !== '0) begin
            errors++; $display("FAIL reset_ks_data: %h required 0", ks_data);
        end
        checks++;
        if ({raddr_1, waddr_2, addr_3, wdata_2, wdata_3, k_addr} !== '0) begin
            errors++; $display("FAIL reset_ram_ports: %h required 0",
                               {raddr_1, waddr_2, addr_3, wdata_2, wdata_3, k_addr});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: busy=%b required 0", busy);
        end
    endtask

    task automatic test_key_vector();
        logic [NB*8-1:0] w;
        int n;
        ks_ready = 1'b1;
        ref_gen(key_key(), 3, 2*NB);
        start_run(key_key(), 5'd3);
        checks++;
        if (ks_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL start_accept: valid=%b busy=%b required 0 1", ks_valid, busy);
        end
        get_word(w, n);
        checks++;
        if (n !== 640 + 3*NB) begin
            errors++; $display("FAIL first_latency: %0d cycles required %0d", n, 640 + 3*NB);
        end
        checks++;
        if (w !== 32'h81779FEB || w !== ref_word(0)) begin
            errors++; $display("FAIL key_word0: %h required %h", w, 32'h81779FEB);
        end
        get_word(w, n);
        checks++;
        if (n !== 3*NB + 1) begin
            errors++; $display("FAIL throughput: %0d cycles required %0d", n, 3*NB + 1);
        end
        checks++;
        if (w !== 32'h72CA34B7 || w !== ref_word(1)) begin
            errors++; $display("FAIL key_word1: %h required %h", w, 32'h72CA34B7);
        end
        stop_pulse();
    endtask

    task automatic test_wiki();
        logic [NB*8-1:0] w;
        int n;
        ks_ready = 1'b1;
        start_run({96'h0, 8'h69, 8'h6B, 8'h69, 8'h57}, 5'd4);
        get_word(w, n);
        checks++;
        if (w !== 32'h6DDB4460) begin
            errors++; $display("FAIL wiki_word0: %h required %h", w, 32'h6DDB4460);
        end
        stop_pulse();
    endtask

    task automatic test_stall();
        logic [NB*8-1:0] w;
        int n;
        ks_ready = 1'b0;
        start_run({80'h0, 8'h74, 8'h65, 8'h72, 8'h63, 8'h65, 8'h53}, 5'd6);
        get_word(w, n);
        checks++;
        if (w !== 32'h056BD404) begin
            errors++; $display("FAIL secret_word0: %h required %h", w, 32'h056BD404);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({ks_valid, wen, ks_data} !== {1'b1, 1'b0, 32'h056BD404}) begin
                errors++; $display("FAIL stall_hold: cycle %0d valid=%b wen=%b data=%h required 1 0 056bd404",
                                   c, ks_valid, wen, ks_data);
            end
        end
        ks_ready = 1'b1;
        get_word(w, n);
        checks++;
        if (w !== 32'h597BA83C) begin
            errors++; $display("FAIL secret_word1: %h required %h", w, 32'h597BA83C);
        end
        stop_pulse();
    endtask

    task automatic test_stop();
        logic [NB*8-1:0] w;
        int n;
        ks_ready = 1'b1;
        start_run({KB*8{1'b1}}, 5'd16);
        repeat (300) @(negedge clk);
        stop = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, wen, ks_valid} !== 3'b000) begin
            errors++; $display("FAIL stop_in_ksa: busy/wen/valid=%b required 000", {busy, wen, ks_valid});
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL stop_over_start: busy=%b required 0", busy);
        end
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        start_run(key_key(), 5'd3);
        get_word(w, n);
        checks++;
        if (w !== 32'h81779FEB || n !== 640 + 3*NB) begin
            errors++; $display("FAIL restart_word0: %h after %0d required 81779feb after %0d", w, n, 640 + 3*NB);
        end
        ks_ready = 1'b0;
        @(negedge clk);
        stop = 1'b1; ks_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, ks_valid} !== 2'b00) begin
            errors++; $display("FAIL stop_over_ready: busy/valid=%b required 00", {busy, ks_valid});
        end
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [NB*8-1:0] w;
        int n;
        ks_ready = 1'b1;
        start_run(key_key(), 5'd3);
        get_word(w, n);
        get_word(w, n);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, ks_valid, wen, ks_data, raddr_1, waddr_2, addr_3, wdata_2, wdata_3, k_addr} !== '0) begin
            errors++; $display("FAIL async_reset_outputs: busy=%b valid=%b wen=%b data=%h ports nonzero, required all 0",
                               busy, ks_valid, wen, ks_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_run(key_key(), 5'd3);
        get_word(w, n);
        checks++;
        if (w !== 32'h81779FEB || n !== 640 + 3*NB) begin
            errors++; $display("FAIL post_reset_word0: %h after %0d required 81779feb after %0d", w, n, 640 + 3*NB);
        end
        get_word(w, n);
        checks++;
        if (w !== 32'h72CA34B7) begin
            errors++; $display("FAIL post_reset_word1: %h required 72ca34b7", w);
        end
        stop_pulse();
    endtask

    task automatic test_key_len_zero();
        logic [KB*8-1:0] k;
        logic [NB*8-1:0] w0 [3];
        logic [NB*8-1:0] w16 [3];
        int n;
        for (int b = 0; b < KB; b++) k[b*8 +: 8] = 8'(b);
        ks_ready = 1'b1;
        ref_gen(k, 16, 3*NB);
        start_run(k, 5'd0);
        for (int w = 0; w < 3; w++) get_word(w0[w], n);
        stop_pulse();
        start_run(k, 5'd16);
        for (int w = 0; w < 3; w++) get_word(w16[w], n);
        stop_pulse();
        for (int w = 0; w < 3; w++) begin
            checks++;
            if (w0[w] !== w16[w] || w0[w] !== ref_word(w)) begin
                errors++; $display("FAIL key_len0_word%0d: len0=%h len16=%h required %h", w, w0[w], w16[w], ref_word(w));
            end
        end
    endtask

    task automatic test_random();
        logic [KB*8-1:0] k;
        logic [4:0] len;
        logic [NB*8-1:0] w;
        int n, gap;
        for (int it = 0; it < 4; it++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            len = 5'($urandom_range(0, 31));
            ref_gen(k, int'(len), 3*NB);
            ks_ready = 1'b1;
            start_run(k, len);
            for (int wi = 0; wi < 3; wi++) begin
                get_word(w, n);
                checks++;
                if (w !== ref_word(wi)) begin
                    errors++; $display("FAIL random_word: iter %0d len %0d word %0d got %h required %h",
                                       it, len, wi, w, ref_word(wi));
                end
                gap = $urandom_range(0, 5);
                ks_ready = 1'b0;
                repeat (gap) @(negedge clk);
                ks_ready = 1'b1;
            end
            stop_pulse();
        end
    endtask

    initial begin
        test_reset();
        test_key_vector();
        test_wiki();
        test_stall();
        test_stop();
        test_reset_mid();
        test_key_len_zero();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rc4_ctrl.md
RC4_CTRL -- requirements
Module: rc4_ctrl

Interface
REQ-001 The block SHALL have parameter NUMS_OF_BYTES, default 4, giving keystream bytes per output word and the number of k_addr/k_data lanes.
REQ-002 The block SHALL have parameter KEY_BYTES, default 16, giving the maximum key length in bytes.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 start  in  1  one-cycle request; sampled only in IDLE.
REQ-006 stop  in  1  abort; returns the block to IDLE.
REQ-007 key  in  KEY_BYTES*8  key bytes; byte b occupies [b*8+:8]; latched on accepted start.
REQ-008 key_len  in  5  key length in bytes; 0 or values above KEY_BYTES are treated as KEY_BYTES; latched on accepted start.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 ks_data  out  NUMS_OF_BYTES*8  keystream word; the first generated byte is in [7:0].
REQ-011 ks_valid  out  1  ks_data is valid; ks_data is held stable while ks_valid=1 and ks_ready=0.
REQ-012 ks_ready  in  1  consumer accept; a word transfers on a cycle with ks_valid=1 and ks_ready=1.
REQ-013 wen, raddr_1[8], waddr_2[8], addr_3[8], wdata_2[8], wdata_3[8], k_addr[NUMS_OF_BYTES*8]  out  state-RAM control.
- Reads are combinational.
- Both writes (waddr_2/wdata_2 and addr_3/wdata_3) occur on the clock edge when wen=1.
REQ-014 rdata_1[8], rdata_3[8], k_data[NUMS_OF_BYTES*8]  in  state-RAM read data.

Function
REQ-015 FSM states SHALL be: IDLE, INIT, KSA_A, KSA_B, PRGA_A, PRGA_B, PRGA_C, OUT.
REQ-016 IDLE: start=1 SHALL latch key and key_len, clear the i, j, key-index and byte counters, and go to INIT. start outside IDLE SHALL be ignored.
REQ-017 INIT SHALL run 128 cycles; in cycle n it SHALL write S[2n]=2n via port 2 and S[2n+1]=2n+1 via port 3 with wen=1, then go to KSA_A with i=0, j=0.
REQ-018 KSA_A SHALL drive raddr_1=i, register si=rdata_1, and register j=j+rdata_1+key[kidx] (all arithmetic mod 256).
REQ-019 KSA_B SHALL perform the swap with wen=1:
- addr_3=j, wdata_3=si;
- waddr_2=i, wdata_2=rdata_3.
REQ-020 KSA_B SHALL then advance kidx, wrapping to 0 at key_len. After i=255 it SHALL go to PRGA_A with i=0, j=0; otherwise it SHALL increment i and return to KSA_A.
REQ-021 The case i==j SHALL need no special handling: both writes carry the same value.
REQ-022 PRGA_A SHALL set i=i+1, drive raddr_1=i+1, register si, and register j=j+si.
REQ-023 PRGA_B SHALL swap as in REQ-019 and register t=si+rdata_3 (mod 256).
REQ-024 PRGA_C SHALL drive lane bidx of k_addr with t (other lanes 0) and capture k_data lane bidx into ks_data byte bidx.
REQ-025 After PRGA_C: if bidx=NUMS_OF_BYTES-1, the FSM SHALL go to OUT with ks_valid=1; otherwise it SHALL increment bidx and return to PRGA_A.
REQ-026 OUT SHALL hold until ks_ready=1, then clear ks_valid and bidx and go to PRGA_A. Generation continues until stop.
REQ-027 wen SHALL be 1 only in INIT, KSA_B and PRGA_B.
REQ-028 stop=1 in any state SHALL force IDLE on the next edge with wen=0, ks_valid=0 and busy=0. stop takes priority over start and over ks_ready.
REQ-029 Latency: if start is accepted at edge E0, ks_valid SHALL first be 1 after edge E(640+3*NUMS_OF_BYTES).
REQ-030 In steady state, with ks_ready held high, one word SHALL be produced every 3*NUMS_OF_BYTES+1 cycles.

Reset
REQ-031 rst_n=0 SHALL asynchronously force:
- state=IDLE;
- busy=0, ks_valid=0, wen=0, ks_data=0;
- all counters and registers (i, j, si, t, kidx, bidx, latched key, latched key_len) to 0.
- all RAM address and data outputs to 0.
REQ-032 Reset mid-operation SHALL abandon the operation. State-RAM contents are don't-care afterwards because INIT rewrites them on the next start.

Structure
REQ-033 Shared package rc4_pkg SHALL hold: the state enum, INIT_CYCLES=128, SBOX_SIZE=256, and the key-length clamp constant.
REQ-034 The keystream byte packer (bidx lanes, ks_data, ks_valid/ks_ready hold) SHALL be a single sub-module rc4_ks_packer.
REQ-035 The state RAM is instantiated beside rc4_ctrl in the parent and not inside it.

Verification
REQ-036 Key 4B 65 79, key_len=3, NUMS_OF_BYTES=4, ks_ready=1 -> words 0x81779FEB, 0x72CA34B7; the first ks_valid occurs 652 cycles after start.
REQ-037 Key "Wiki" (57 69 6B 69), key_len=4 -> first word 0x6DDB4460.
REQ-038 Key "Secret", key_len=6, ks_ready held 0 for 20 cycles after the first ks_valid -> ks_data stays 0x056BD404 and wen stays 0 during the stall; the second word is 0x597BA83C.
REQ-039 stop asserted in the KSA phase, then a new start with key 4B 65 79 -> IDLE and wen=0 on the next edge; the second run again yields 0x81779FEB.
REQ-040 rst_n pulsed low asynchronously mid-PRGA -> all outputs are 0 immediately; start after release reproduces the REQ-036 vector.
REQ-041 key_len=0 with a 16-byte key 00..0F -> keystream identical to a run with key_len=16.
